// File: rtl/button_debounce.sv
// Debounces raw active-low button pins: two-flop synchronizer, per-channel
// stability counter, and one-cycle press/release pulses.
module button_debounce #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int CNT_W           = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn,
    output logic [N-1:0] pressed,
    output logic [N-1:0] released
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    // Synchronizer resets to "released" so a held button reads as a fresh press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi = gi + 1) begin : g_chan
            logic [CNT_W-1:0] r_cnt;
            logic             r_btn;
            logic             r_pressed;
            logic             r_released;
            logic             w_differs;
            logic             w_stable;

            assign w_differs = (r_sync2[gi] != r_btn);
            assign w_stable  = (r_cnt == CNT_MAX);

            // Any cycle of agreement restarts the count; the counter stops at
            // CNT_MAX because reaching it always flips the state and clears it.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt      <= '0;
                    r_btn      <= 1'b1;
                    r_pressed  <= 1'b0;
                    r_released <= 1'b0;
                end else begin
                    r_pressed  <= 1'b0;
                    r_released <= 1'b0;
                    if (!w_differs) begin
                        r_cnt <= '0;
                    end else if (w_stable) begin
                        r_cnt      <= '0;
                        r_btn      <= r_sync2[gi];
                        r_pressed  <= ~r_sync2[gi];
                        r_released <= r_sync2[gi];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign btn[gi]      = r_btn;
            assign pressed[gi]  = r_pressed;
            assign released[gi] = r_released;
        end
    endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce (N=8, DEBOUNCE_CYCLES=4): stimulus queues
// expected pulse events, a monitor pops and compares whenever a pulse appears.
module tb_button_debounce;

    logic       clk;
    logic       rst_n;
    logic [7:0] btn_raw;
    logic [7:0] btn;
    logic [7:0] pressed;
    logic [7:0] released;

    button_debounce #(
        .N               (8),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn      (btn),
        .pressed  (pressed),
        .released (released)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] r;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every nonzero pulse vector is one transaction.
    always @(negedge clk) begin
        if ((pressed | released) != 8'h00) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d btn=%h pressed=%h released=%h, none expected",
                         cyc, btn, pressed, released);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.b != btn || e.p != pressed || e.r != released) begin
                    errors++;
                    $display("FAIL %s: got cyc=%0d btn=%h pressed=%h released=%h, expected cyc=%0d btn=%h pressed=%h released=%h",
                             e.name, cyc, btn, pressed, released, e.cyc, e.b, e.p, e.r);
                end else begin
                    $display("event %s: cyc=%0d btn=%h pressed=%h released=%h ok",
                             e.name, cyc, btn, pressed, released);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string name, input int dly, input logic [7:0] b,
                        input logic [7:0] p, input logic [7:0] r);
        exp_t e;
        e.name = name;
        e.cyc  = cyc + dly;
        e.b    = b;
        e.p    = p;
        e.r    = r;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    logic [10:0] bounce_pat;

    initial begin
        rst_n   = 1'b0;
        btn_raw = 8'h00;
        bounce_pat = 11'b00010010000;

        // Reset with every button held.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_btn", btn, 8'hFF);
            check("reset_pulses", pressed | released, 8'h00);
        end
        rst_n = 1'b1;
        push("reset_release", 6, 8'h00, 8'hFF, 8'h00);
        tick(10);
        check("held_btn", btn, 8'h00);

        btn_raw = 8'hFF;
        push("release_all", 6, 8'hFF, 8'h00, 8'hFF);
        tick(10);

        // Clean press then release on channel 3.
        btn_raw = 8'hF7;
        push("press3", 6, 8'hF7, 8'h08, 8'h00);
        tick(20);
        check("hold3_btn", btn, 8'hF7);
        btn_raw = 8'hFF;
        push("release3", 6, 8'hFF, 8'h00, 8'h08);
        tick(10);
        check("idle_btn", btn, 8'hFF);

        // Bounce on channel 0: final run of zeros starts 7 cycles in.
        push("bounce0", 13, 8'hFE, 8'h01, 8'h00);
        for (int j = 0; j < 11; j++) begin
            btn_raw = {7'h7F, bounce_pat[10-j]};
            tick(1);
        end
        tick(6);
        check("bounce_btn", btn, 8'hFE);
        btn_raw = 8'hFF;
        push("release0", 6, 8'hFF, 8'h00, 8'h01);
        tick(10);

        // Three-cycle glitch on channel 5 is rejected.
        btn_raw = 8'hDF;
        tick(3);
        btn_raw = 8'hFF;
        tick(10);
        check("glitch_btn", btn, 8'hFF);

        // Mixed simultaneous events.
        btn_raw = 8'hF0;
        push("press_lo", 6, 8'hF0, 8'h0F, 8'h00);
        tick(10);
        btn_raw = 8'h0F;
        push("swap", 6, 8'h0F, 8'hF0, 8'h0F);
        tick(10);
        btn_raw = 8'hFF;
        push("release_hi", 6, 8'hFF, 8'h00, 8'hF0);
        tick(10);

        // Reset on the 4th edge after a press discards the partial count.
        btn_raw = 8'hFB;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("midreset_btn", btn, 8'hFF);
        check("midreset_pulses", pressed | released, 8'h00);
        rst_n = 1'b1;
        push("press2_after_reset", 6, 8'hFB, 8'h04, 8'h00);
        tick(10);
        check("final_btn", btn, 8'hFB);

        for (int k = 0; k < 20 && q.size() != 0; k++) tick(1);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no event, expected cyc=%0d btn=%h pressed=%h released=%h",
                     e.name, e.cyc, e.b, e.p, e.r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the badge button inputs. Takes the raw, asynchronous, active-low button pins.
- Produces a synchronized, debounced, still active-low button vector. This vector feeds the priority button-number encoder.
- Also emits one-cycle press/release pulses per button for event-driven consumers (audio note triggering, menu logic).

Parameters:
N, 8, number of button channels
DEBOUNCE_CYCLES, 48000, consecutive cycles a synchronized input must differ from the debounced state before the debounced state flips (1 ms at 48 MHz); legal range 1..2^CNT_W-1
CNT_W, 16, width of each per-channel stability counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
btn_raw  input  N  raw button pins, active-low (0 = pressed), asynchronous to clk
btn  output  N  debounced buttons, active-low, registered
pressed  output  N  one-cycle pulse per channel on debounced 1->0 transition
released  output  N  one-cycle pulse per channel on debounced 0->1 transition

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - btn = all 1s (all released).
  - pressed = 0, released = 0.
  - Both synchronizer stages = all 1s.
  - All counters = 0.
  - Reset applies in any state, including mid-count; in-progress counts are discarded.
- Synchronizer: two flop stages per channel, sync1 <= btn_raw and sync2 <= sync1. Only sync2 is used downstream.
- Per-channel stability logic (channels fully independent):
  - Case sync2[i] == btn[i]: cnt[i] <= 0.
  - Case sync2[i] != btn[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - Case sync2[i] != btn[i] and cnt[i] == DEBOUNCE_CYCLES-1:
    - btn[i] <= sync2[i] and cnt[i] <= 0.
    - pressed[i] <= 1 if sync2[i]==0; released[i] <= 1 if sync2[i]==1.
  - pressed/released default to 0 every cycle. They are high only in the single cycle in which btn[i] first shows its new value.
- Latency:
  - A raw level change reaches sync2 after 2 edges.
  - btn updates DEBOUNCE_CYCLES edges after that, i.e. 2+DEBOUNCE_CYCLES edges from the first edge sampling the new raw level.
  - For DEBOUNCE_CYCLES=1, btn follows sync2 with 1 edge of delay.
- Glitch rejection: a disagreement lasting fewer than DEBOUNCE_CYCLES consecutive sync2 cycles produces no btn change and no pulse. Any cycle of agreement restarts the count from 0.
- Simultaneous events: any number of channels may flip in the same cycle. pressed and released may be nonzero in the same cycle on different channels, never on the same channel.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Button held through reset: after rst_n deasserts, that channel is treated as a fresh press. pressed fires 2+DEBOUNCE_CYCLES edges after the first non-reset edge.
- Continuous hold after debounce produces no further pulses (no auto-repeat in this block).

Test Plan (bench uses N=8, DEBOUNCE_CYCLES=4):
- Reset check: hold rst_n=0 with btn_raw=8'h00 -> btn=8'hFF, pressed=0, released=0 throughout reset. Release rst_n -> btn=8'h00 and pressed=8'hFF exactly 6 edges later, pressed=0 the next cycle.
- Clean press/release: btn_raw[3] 1->0 -> btn[3]=0 and pressed[3]=1 for one cycle, 6 edges later. btn_raw[3] back to 1 after 20 cycles -> btn[3]=1 and released[3]=1 for one cycle, 6 edges later. No other bits toggle.
- Bounce rejection: btn_raw[0] pattern 0,0,0,1,0,0,1,0,0,0,0 (one value per cycle) -> btn[0] goes to 0 only after the final run of four stable zeros clears the synchronizer. Exactly one pressed[0] pulse is seen.
- Short glitch: btn_raw[5]=0 for 3 cycles then 1 -> btn stays 8'hFF; pressed and released stay 0.
- Simultaneous mixed events: btn already 8'hF0; same cycle set btn_raw=8'h0F -> 6 edges later btn=8'h0F, pressed=8'hF0, released=8'h0F in the same single cycle.
- Reset mid-count: btn_raw[2] 1->0, assert rst_n=0 on the 4th edge after the change, release next cycle -> btn=8'hFF during reset. The count restarts: pressed[2] fires 6 edges after reset release, not earlier.
